// File: rtl/nexys_starship_break_gen.sv
// Part-break initiator: schedules random breakdowns for the repair state machines.
// It waits a random gap counted in game ticks, then raises a one-hot request with a
// nonzero repair combo. The request is held until the target part acks as broken or
// until a tick-counted timeout expires.
module nexys_starship_break_gen #(
    parameter int unsigned NUM_PARTS    = 4,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int unsigned MIN_GAP      = 8,
    parameter logic [3:0]  GAP_MASK     = 4'hF,
    parameter int unsigned FIRE_TIMEOUT = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 timer_clk,
    input  logic                 play_flag,
    input  logic                 gameover_ctrl,
    input  logic [NUM_PARTS-1:0] broken,
    output logic [NUM_PARTS-1:0] part_random,
    output logic [3:0]           random_hex,
    output logic [7:0]           break_count,
    output logic                 q_BG_Idle,
    output logic                 q_BG_Wait,
    output logic                 q_BG_Fire
);

    // One-hot encoding so the state outputs come straight from flops.
    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StWait = 3'b010,
        StFire = 3'b100
    } state_e;

    localparam logic [NUM_PARTS-1:0] OneHotLsb = {{(NUM_PARTS-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [NUM_PARTS-1:0] part_random_q, part_random_d;
    logic [3:0]           random_hex_q, random_hex_d;
    logic [7:0]           break_count_q, break_count_d;
    // Gap can reach MIN_GAP + 15, so one bit wider than a byte.
    logic [8:0]           gap_q, gap_d;
    logic [7:0]           tout_q, tout_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 timer_q, timer_d;

    logic                 tick;
    logic                 ack;
    logic [8:0]           gap_reload;
    logic [3:0]           hex_pick;
    logic [15:0]          lfsr_next;
    logic                 pick_found;
    logic [NUM_PARTS-1:0] pick_oh;
    logic [NUM_PARTS-1:0] cand_oh;
    int unsigned          base_idx;
    int unsigned          cand;

    // Tick edge detect, LFSR step, gap reload and combo values shared by the FSM.
    always_comb begin
        tick       = timer_clk & ~timer_q;
        ack        = |(broken & part_random_q);
        gap_reload = 9'(MIN_GAP) + 9'(lfsr_q[3:0] & GAP_MASK);
        hex_pick   = (lfsr_q[11:8] == 4'h0) ? 4'h1 : lfsr_q[11:8];
        lfsr_next  = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
    end

    // Target pick: start at lfsr[6:4] mod NUM_PARTS, rotate upward past broken parts.
    always_comb begin
        base_idx   = 32'(lfsr_q[6:4]) % NUM_PARTS;
        pick_found = 1'b0;
        pick_oh    = '0;
        cand       = 0;
        cand_oh    = '0;
        for (int unsigned k = 0; k < NUM_PARTS; k++) begin
            cand    = (base_idx + k) % NUM_PARTS;
            cand_oh = OneHotLsb << cand;
            if (!pick_found && ((broken & cand_oh) == '0)) begin
                pick_found = 1'b1;
                pick_oh    = cand_oh;
            end
        end
    end

    // Next-state logic for the scheduler FSM and its registered outputs.
    always_comb begin
        state_d       = state_q;
        part_random_d = part_random_q;
        random_hex_d  = random_hex_q;
        break_count_d = break_count_q;
        gap_d         = gap_q;
        tout_d        = tout_q;
        timer_d       = timer_clk;
        lfsr_d        = (lfsr_q == 16'h0) ? SEED : lfsr_next;

        unique case (state_q)
            StIdle: begin
                part_random_d = '0;
                random_hex_d  = 4'h0;
                if (play_flag && !gameover_ctrl) begin
                    state_d       = StWait;
                    gap_d         = gap_reload;
                    break_count_d = 8'd0;
                end
            end
            StWait: begin
                if (gameover_ctrl) begin
                    state_d       = StIdle;
                    part_random_d = '0;
                    random_hex_d  = 4'h0;
                end else if (gap_q == 9'd0) begin
                    if (pick_found) begin
                        state_d       = StFire;
                        part_random_d = pick_oh;
                        random_hex_d  = hex_pick;
                        tout_d        = 8'd0;
                    end else begin
                        // Every part already broken: wait another full gap.
                        gap_d = gap_reload;
                    end
                end else if (tick) begin
                    gap_d = gap_q - 9'd1;
                end
            end
            StFire: begin
                if (gameover_ctrl) begin
                    state_d       = StIdle;
                    part_random_d = '0;
                    random_hex_d  = 4'h0;
                end else if (ack) begin
                    state_d       = StWait;
                    part_random_d = '0;
                    gap_d         = gap_reload;
                    if (break_count_q != 8'hFF) begin
                        break_count_d = break_count_q + 8'd1;
                    end
                end else if (tick) begin
                    if (tout_q == 8'(FIRE_TIMEOUT - 1)) begin
                        state_d       = StWait;
                        part_random_d = '0;
                        gap_d         = gap_reload;
                    end else begin
                        tout_d = tout_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d       = StIdle;
                part_random_d = '0;
                random_hex_d  = 4'h0;
            end
        endcase
    end

    // State register; asynchronous reset drops any pending request immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StIdle;
            part_random_q <= '0;
            random_hex_q  <= 4'h0;
            break_count_q <= 8'd0;
            gap_q         <= 9'd0;
            tout_q        <= 8'd0;
            lfsr_q        <= SEED;
            timer_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            part_random_q <= part_random_d;
            random_hex_q  <= random_hex_d;
            break_count_q <= break_count_d;
            gap_q         <= gap_d;
            tout_q        <= tout_d;
            lfsr_q        <= lfsr_d;
            timer_q       <= timer_d;
        end
    end

    assign part_random = part_random_q;
    assign random_hex  = random_hex_q;
    assign break_count = break_count_q;
    assign q_BG_Idle   = state_q[0];
    assign q_BG_Wait   = state_q[1];
    assign q_BG_Fire   = state_q[2];

endmodule
